trivial_multiplier_fft: RTL and testbench

Forward-FFT counterpart of the IFFT trivial twiddle stage. It multiplies selected samples by -j, where the IFFT stage multiplies by +j. It generates its own sample index from a valid/start-of-frame stream instead of taking an external address. It sits between radix-2 butterfly stages in the 64-point SDF mixed-radix FFT and has one registered pipeline stage.

---
 rtl/trivial_multiplier_fft.sv | 146 ++++++++++++++
 tb/tb_trivial_multiplier_fft.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/trivial_multiplier_fft.sv
// Forward-FFT trivial twiddle stage: multiplies the last quarter of every block by -j,
// deriving the sample index from a valid / start-of-frame stream. One registered stage.
module trivial_multiplier_fft #(
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE   = 12,
  parameter int NFFT         = 64,
  parameter int BLOCK_SIZE   = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic                                 in_sof,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]   in_r,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]   in_i,
  output logic                                 out_valid,
  output logic                                 out_sof,
  output logic                                 out_eof,
  output logic [INTEGER_SIZE+FRACT_SIZE-1:0]   out_r,
  output logic [INTEGER_SIZE+FRACT_SIZE-1:0]   out_i,
  output logic                                 sat_pulse,
  output logic                                 resync_pulse
);

  localparam int DATA_WIDTH = INTEGER_SIZE + FRACT_SIZE;
  localparam int CNT_W      = $clog2(NFFT);
  localparam int BLK_W      = $clog2(BLOCK_SIZE);

  localparam logic [CNT_W-1:0]      ZERO_IDX = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      ONE_IDX  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      LAST_IDX = {CNT_W{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_VAL  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] ONE_VAL  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Saturating negation; MSB of the result flags that the most negative value was clamped.
  function automatic logic [DATA_WIDTH:0] neg_sat(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH:0] res;
    if (x == MIN_VAL) begin
      res = {1'b1, MAX_VAL};
    end else begin
      res = {1'b0, (~x) + ONE_VAL};
    end
    return res;
  endfunction

  logic [CNT_W-1:0]      cnt_r;
  logic                  active_r;

  logic [CNT_W-1:0]      idx_s;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic                  active_nxt_s;
  logic                  rot_s;
  logic                  resync_s;
  logic [DATA_WIDTH:0]   neg_s;
  logic [DATA_WIDTH-1:0] res_r_s;
  logic [DATA_WIDTH-1:0] res_i_s;
  logic                  sat_s;

  // Index generation, frame tracking and the -j rotation datapath.
  always_comb begin
    idx_s        = cnt_r;
    cnt_nxt_s    = cnt_r;
    active_nxt_s = active_r;
    rot_s        = 1'b0;
    resync_s     = 1'b0;
    neg_s        = {(DATA_WIDTH+1){1'b0}};
    res_r_s      = in_r;
    res_i_s      = in_i;
    sat_s        = 1'b0;

    if (in_sof) begin
      idx_s = ZERO_IDX;
    end else begin
      idx_s = cnt_r;
    end

    // A start-of-frame landing exactly on the wrap point is a normal frame boundary.
    resync_s  = in_sof & active_r & (cnt_r != ZERO_IDX);
    cnt_nxt_s = idx_s + ONE_IDX;

    if (idx_s == ZERO_IDX) begin
      active_nxt_s = 1'b1;
    end else if (idx_s == LAST_IDX) begin
      active_nxt_s = 1'b0;
    end else begin
      active_nxt_s = active_r;
    end

    rot_s = (idx_s[BLK_W-1 -: 2] == 2'b11);
    neg_s = neg_sat(in_r);

    if (rot_s) begin
      res_r_s = in_i;
      res_i_s = neg_s[DATA_WIDTH-1:0];
      sat_s   = neg_s[DATA_WIDTH];
    end else begin
      res_r_s = in_r;
      res_i_s = in_i;
      sat_s   = 1'b0;
    end
  end

  // Sample counter and frame-active flag advance only on accepted samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      active_r <= 1'b0;
    end else if (in_valid) begin
      cnt_r    <= cnt_nxt_s;
      active_r <= active_nxt_s;
    end else begin
      cnt_r    <= cnt_r;
      active_r <= active_r;
    end
  end

  // Output register: data holds across idle cycles, flags and pulses drop to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
      out_r        <= {DATA_WIDTH{1'b0}};
      out_i        <= {DATA_WIDTH{1'b0}};
      sat_pulse    <= 1'b0;
      resync_pulse <= 1'b0;
    end else if (in_valid) begin
      out_valid    <= 1'b1;
      out_sof      <= (idx_s == ZERO_IDX);
      out_eof      <= (idx_s == LAST_IDX);
      out_r        <= res_r_s;
      out_i        <= res_i_s;
      sat_pulse    <= sat_s;
      resync_pulse <= resync_s;
    end else begin
      out_valid    <= 1'b0;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
      out_r        <= out_r;
      out_i        <= out_i;
      sat_pulse    <= 1'b0;
      resync_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trivial_multiplier_fft.sv
// Self-checking bench for trivial_multiplier_fft: two instances (block 64 and block 16)
// share one directed stimulus stream; a reference model fills per-instance scoreboards.
module tb_trivial_multiplier_fft;

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic        sat;
    logic        resync;
    logic [17:0] r;
    logic [17:0] i;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [17:0] in_r = 18'd0;
  logic [17:0] in_i = 18'd0;

  logic        v64, sof64, eof64, sat64, rs64;
  logic [17:0] r64, i64;
  logic        v16, sof16, eof16, sat16, rs16;
  logic [17:0] r16, i16;

  exp_t        q64[$];
  exp_t        q16[$];
  int          tests = 0;
  int          fails = 0;
  int          m_cnt = 0;
  bit          m_active = 1'b0;
  logic [17:0] lr64 = 18'd0, li64 = 18'd0, lr16 = 18'd0, li16 = 18'd0;

  trivial_multiplier_fft #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(64), .BLOCK_SIZE(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_r(in_r), .in_i(in_i),
    .out_valid(v64), .out_sof(sof64), .out_eof(eof64), .out_r(r64), .out_i(i64),
    .sat_pulse(sat64), .resync_pulse(rs64)
  );

  trivial_multiplier_fft #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(64), .BLOCK_SIZE(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_r(in_r), .in_i(in_i),
    .out_valid(v16), .out_sof(sof16), .out_eof(eof16), .out_r(r16), .out_i(i16),
    .sat_pulse(sat16), .resync_pulse(rs16)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int idx, int blk, bit resync, logic [17:0] r, logic [17:0] i);
    exp_t e;
    int   rv;
    int   nv;
    e.sof    = (idx == 0);
    e.eof    = (idx == 63);
    e.resync = resync;
    if ((idx % blk) >= (blk * 3) / 4) begin
      rv = int'($signed(r));
      if (rv == -131072) begin
        nv    = 131071;
        e.sat = 1'b1;
      end else begin
        nv    = -rv;
        e.sat = 1'b0;
      end
      e.r = i;
      e.i = 18'(nv);
    end else begin
      e.r   = r;
      e.i   = i;
      e.sat = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [40:0] obs, input logic [40:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of input, update the model, then compare once the output register has loaded.
  task automatic step(input bit v, input bit s, input logic [17:0] r, input logic [17:0] i);
    int   idx;
    bit   rsy;
    exp_t e;
    in_valid = v;
    in_sof   = s;
    in_r     = r;
    in_i     = i;
    if (v) begin
      idx = s ? 0 : m_cnt;
      rsy = s && m_active && (m_cnt != 0);
      if (idx == 0) m_active = 1'b1;
      else if (idx == 63) m_active = 1'b0;
      m_cnt = (idx + 1) % 64;
      q64.push_back(model(idx, 64, rsy, r, i));
      q16.push_back(model(idx, 16, rsy, r, i));
    end
    @(posedge clk);
    #1;
    if (v) begin
      if (q64.size() == 0 || q16.size() == 0) begin
        chk("scoreboard_empty", 41'd1, 41'd0);
      end else begin
        e = q64.pop_front();
        lr64 = e.r; li64 = e.i;
        chk("out64", {v64, sof64, eof64, sat64, rs64, r64, i64},
            {1'b1, e.sof, e.eof, e.sat, e.resync, e.r, e.i});
        e = q16.pop_front();
        lr16 = e.r; li16 = e.i;
        chk("out16", {v16, sof16, eof16, sat16, rs16, r16, i16},
            {1'b1, e.sof, e.eof, e.sat, e.resync, e.r, e.i});
      end
    end else begin
      chk("idle64", {v64, sof64, eof64, sat64, rs64, r64, i64}, {5'b00000, lr64, li64});
      chk("idle16", {v16, sof16, eof16, sat16, rs16, r16, i16}, {5'b00000, lr16, li16});
    end
  endtask

  initial begin
    // Reset held, then released with the input idle.
    repeat (2) @(posedge clk);
    #1;
    chk("reset64", {v64, sof64, eof64, sat64, rs64, r64, i64}, 41'd0);
    chk("reset16", {v16, sof16, eof16, sat16, rs16, r16, i16}, 41'd0);
    rst = 1'b1;
    repeat (5) step(1'b0, 1'b0, 18'd0, 18'd0);

    // Frame of 1.0 real samples through the block-64 pattern.
    for (int k = 0; k < 64; k++) begin
      step(1'b1, k == 0, 18'd4096, 18'd0);
      if (k == 47) chk("pass47", {23'd0, r64, i64}, {23'd0, 18'd4096, 18'd0});
      if (k == 48) chk("rot48", {23'd0, r64, i64}, {23'd0, 18'd0, 18'h3F000});
      if (k == 63) chk("eof63", {39'd0, sof64, eof64}, {39'd0, 2'b01});
    end

    // Frame of (100,-200): the block-16 instance rotates idx 12..15 of every 16.
    for (int k = 0; k < 64; k++) begin
      step(1'b1, k == 0, 18'd100, 18'h3FF38);
      if (k == 11) chk("blk16_pass11", {5'd0, r16, i16}, {5'd0, 18'd100, 18'h3FF38});
      if (k == 12) chk("blk16_rot12", {5'd0, r16, i16}, {5'd0, 18'h3FF38, 18'h3FF9C});
    end

    // Saturation on the most negative real input, plain negation one sample later.
    for (int k = 0; k < 64; k++) begin
      if (k == 48) step(1'b1, 1'b0, 18'h20000, 18'd5);
      else if (k == 49) step(1'b1, 1'b0, 18'h1FFFF, 18'd7);
      else step(1'b1, k == 0, 18'd100, 18'h3FF38);
      if (k == 48) chk("sat48", {4'd0, sat64, r64, i64}, {4'd0, 1'b1, 18'd5, 18'h1FFFF});
      if (k == 49) chk("nosat49", {4'd0, sat64, r64, i64}, {4'd0, 1'b0, 18'd7, 18'h20001});
    end

    // Mid-frame start-of-frame at idx 20 forces a resync and a fresh full frame.
    for (int k = 0; k < 20; k++) step(1'b1, k == 0, 18'd100, 18'h3FF38);
    step(1'b1, 1'b1, 18'd100, 18'h3FF38);
    chk("resync", {38'd0, rs64, sof64, eof64}, {38'd0, 3'b110});
    for (int k = 1; k < 64; k++) step(1'b1, 1'b0, 18'd300, 18'd400);

    // Back-to-back frame: no resync on the wrap, idle gap mid-frame, then async reset.
    step(1'b1, 1'b1, 18'd100, 18'h3FF38);
    chk("b2b_no_resync", {39'd0, rs64, sof64}, {39'd0, 2'b01});
    for (int k = 1; k < 30; k++) begin
      if (k == 10) repeat (3) step(1'b0, 1'b0, 18'd7, 18'd9);
      step(1'b1, 1'b0, 18'd100, 18'h3FF38);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst64", {v64, sof64, eof64, sat64, rs64, r64, i64}, 41'd0);
    chk("async_rst16", {v16, sof16, eof16, sat16, rs16, r16, i16}, 41'd0);
    q64.delete();
    q16.delete();
    m_cnt = 0;
    m_active = 1'b0;
    lr64 = 18'd0; li64 = 18'd0; lr16 = 18'd0; li16 = 18'd0;
    @(negedge clk);
    rst = 1'b1;

    // Samples without start-of-frame after reset count from index 0.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 18'd50, 18'd60);
    step(1'b0, 1'b0, 18'd0, 18'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
